// File: rtl/result_shift_out.sv
// Serial readout of the compressor result columns: capture dst after a settle delay,
// then stream it LSB-first over a valid/ready bit stream, closing with an even-parity beat.
module result_shift_out #(
   parameter int WIDTH  = 38,
   parameter int SETTLE = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dst,
   output logic             sout,
   output logic             sout_valid,
   output logic             sout_last,
   input  logic             sout_ready,
   output logic             busy,
   output logic             done
);

   localparam int              IW          = $clog2(WIDTH + 1);
   localparam logic [IW-1:0]   LAST_DATA   = IW'(WIDTH - 1);
   localparam logic [7:0]      SETTLE_LOAD = (SETTLE > 0) ? 8'(SETTLE - 1) : 8'd0;
   localparam bit              NO_SETTLE   = (SETTLE == 0);

   typedef enum logic [1:0] {IDLE, WAIT, SHIFT, DONE} state_t;

   state_t           state_reg;
   logic [7:0]       cnt_reg;
   logic [IW-1:0]    idx_reg;
   logic [WIDTH-1:0] shreg_reg;
   logic             parity_reg;

   logic             capture;
   logic             accept;
   logic             parity_next;

   // The capture edge is either the start edge itself (no settle) or the last WAIT cycle.
   always_comb begin
      capture = 1'b0;
      if (state_reg == IDLE && start && NO_SETTLE) begin
         capture = 1'b1;
      end
      if (state_reg == WAIT && cnt_reg == 8'd0) begin
         capture = 1'b1;
      end
   end

   assign accept      = sout_valid && sout_ready;
   assign parity_next = parity_reg ^ shreg_reg[0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         cnt_reg    <= 8'd0;
         idx_reg    <= '0;
         shreg_reg  <= '0;
         parity_reg <= 1'b0;
         sout       <= 1'b0;
         sout_valid <= 1'b0;
         sout_last  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         if (capture) begin
            shreg_reg  <= dst;
            idx_reg    <= '0;
            parity_reg <= 1'b0;
            sout       <= dst[0];
            sout_valid <= 1'b1;
            sout_last  <= 1'b0;
            busy       <= 1'b1;
            state_reg  <= SHIFT;
         end else begin
            case (state_reg)
               IDLE: begin
                  if (start) begin
                     cnt_reg   <= SETTLE_LOAD;
                     busy      <= 1'b1;
                     state_reg <= WAIT;
                  end
               end
               WAIT: begin
                  cnt_reg <= cnt_reg - 8'd1;
               end
               SHIFT: begin
                  if (accept) begin
                     if (sout_last) begin
                        sout       <= 1'b0;
                        sout_valid <= 1'b0;
                        sout_last  <= 1'b0;
                        done       <= 1'b1;
                        state_reg  <= DONE;
                     end else begin
                        shreg_reg  <= shreg_reg >> 1;
                        parity_reg <= parity_next;
                        idx_reg    <= idx_reg + 1'b1;
                        // After the final data bit, the next beat carries the accumulated parity.
                        if (idx_reg == LAST_DATA) begin
                           sout      <= parity_next;
                           sout_last <= 1'b1;
                        end else begin
                           sout <= shreg_reg[1];
                        end
                     end
                  end
               end
               DONE: begin
                  busy      <= 1'b0;
                  state_reg <= IDLE;
               end
               default: begin
                  state_reg <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_result_shift_out.sv
// Bench for result_shift_out: two instances (SETTLE=0 and SETTLE=3) share stimulus and
// are checked every cycle against a frame-level model, plus literal frame expectations.
module tb_result_shift_out;

   localparam int WIDTH = 38;
   localparam logic [WIDTH-1:0] ONES = '1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst;
   logic             start;
   logic             sout_ready;
   logic [WIDTH-1:0] dst;
   logic [1:0]       sout_v, valid_v, last_v, busy_v, done_v;

   for (genvar gi = 0; gi < 2; gi++) begin : g
      result_shift_out #(.WIDTH(WIDTH), .SETTLE(gi * 3)) dut (
         .clk(clk),
         .rst(rst),
         .start(start),
         .dst(dst),
         .sout(sout_v[gi]),
         .sout_valid(valid_v[gi]),
         .sout_last(last_v[gi]),
         .sout_ready(sout_ready),
         .busy(busy_v[gi]),
         .done(done_v[gi])
      );
   end

   int checks = 0;
   int fails  = 0;

   // Model: per instance a phase (0 idle, 1 settling, 2 streaming, 3 done) and the frame
   // as a WIDTH+1 bit vector {parity, data} with the index of the beat on offer.
   int             settle [2] = '{0, 3};
   int             phase [2];
   int             wait_left [2];
   logic [WIDTH:0] frame_bits [2];
   int             pos [2];

   // Receiver side: rebuilt frames and event counters.
   logic [WIDTH:0]   partial [2];
   int               nbeats [2];
   logic [WIDTH-1:0] frame_data [2];
   logic             frame_par [2];
   int               frames [2];
   int               dones [2];
   int               busy_run [2];
   int               last_busy [2];
   logic [1:0]       prev_stall, prev_sout, prev_last;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            phase[k] = 0;
         end else begin
            case (phase[k])
               0: if (start) begin
                     if (settle[k] == 0) begin
                        frame_bits[k] = {^dst, dst}; pos[k] = 0; phase[k] = 2;
                     end else begin
                        wait_left[k] = settle[k]; phase[k] = 1;
                     end
                  end
               1: begin
                     wait_left[k]--;
                     if (wait_left[k] == 0) begin
                        frame_bits[k] = {^dst, dst}; pos[k] = 0; phase[k] = 2;
                     end
                  end
               2: if (sout_ready) begin
                     if (pos[k] == WIDTH) phase[k] = 3;
                     else pos[k]++;
                  end
               default: phase[k] = 0;
            endcase
         end
      end
   endtask

   task automatic record_accept();
      for (int k = 0; k < 2; k++) begin
         prev_stall[k] = valid_v[k] && !sout_ready && !rst;
         prev_sout[k]  = sout_v[k];
         prev_last[k]  = last_v[k];
         if (rst) begin
            nbeats[k] = 0;
         end else if (valid_v[k] && sout_ready) begin
            partial[k][nbeats[k]] = sout_v[k];
            if (last_v[k]) begin
               check($sformatf("frame_len%0d", k), 64'(nbeats[k] + 1), 64'(WIDTH + 1));
               frame_data[k] = partial[k][WIDTH-1:0];
               frame_par[k]  = sout_v[k];
               frames[k]++;
               nbeats[k] = 0;
            end else begin
               nbeats[k]++;
            end
         end
      end
   endtask

   task automatic compare_all();
      for (int k = 0; k < 2; k++) begin
         bit ev, el;
         ev = (phase[k] == 2);
         el = ev && (pos[k] == WIDTH);
         check($sformatf("valid%0d", k), 64'(valid_v[k]), 64'(ev));
         check($sformatf("last%0d", k),  64'(last_v[k]),  64'(el));
         check($sformatf("busy%0d", k),  64'(busy_v[k]),  64'(phase[k] != 0));
         check($sformatf("done%0d", k),  64'(done_v[k]),  64'(phase[k] == 3));
         if (ev || phase[k] == 0)
            check($sformatf("sout%0d", k), 64'(sout_v[k]), 64'(ev ? frame_bits[k][pos[k]] : 1'b0));
         if (prev_stall[k]) begin
            check($sformatf("stall_sout%0d", k), 64'(sout_v[k]), 64'(prev_sout[k]));
            check($sformatf("stall_last%0d", k), 64'(last_v[k]), 64'(prev_last[k]));
         end
         if (done_v[k]) dones[k]++;
         if (busy_v[k]) busy_run[k]++;
         else if (busy_run[k] > 0) begin
            last_busy[k] = busy_run[k];
            busy_run[k]  = 0;
         end
      end
   endtask

   // One clock: inputs already set by the caller apply at the coming edge.
   task automatic cyc();
      record_accept();
      model_step();
      @(posedge clk);
      @(negedge clk);
      compare_all();
   endtask

   task automatic wait_quiet(input int budget, input bit rand_ready);
      int n;
      n = 0;
      while ((busy_v != 2'b00 || phase[0] != 0 || phase[1] != 0) && n < budget) begin
         if (rand_ready) sout_ready = 1'($urandom_range(0, 1));
         cyc();
         n++;
      end
      check("wait_budget", 64'(n < budget), 64'(1));
   endtask

   initial begin
      int bf, bd, n;
      logic [WIDTH-1:0] val;
      for (int k = 0; k < 2; k++) begin
         phase[k] = 0; pos[k] = 0; nbeats[k] = 0; frames[k] = 0; dones[k] = 0;
         busy_run[k] = 0; last_busy[k] = 0; frame_bits[k] = '0; wait_left[k] = 0;
         partial[k] = '0; frame_data[k] = '0; frame_par[k] = 1'b0;
      end
      prev_stall = '0; prev_sout = '0; prev_last = '0;
      rst = 1'b1; start = 1'b1; sout_ready = 1'b0; dst = ONES;
      @(negedge clk);

      // Reset with start pulsed, then idle.
      cyc(); cyc();
      rst = 1'b0; start = 1'b0;
      repeat (4) cyc();
      check("idle_busy", 64'(busy_v), 64'(0));
      check("idle_valid", 64'(valid_v), 64'(0));

      // Basic frame.
      bf = frames[0]; bd = dones[0];
      dst = 38'h20_0000_0001; sout_ready = 1'b1; start = 1'b1;
      cyc();
      start = 1'b0;
      wait_quiet(200, 1'b0);
      check("basic_data", 64'(frame_data[0]), 64'(38'h20_0000_0001));
      check("basic_parity", 64'(frame_par[0]), 64'(0));
      check("basic_frames", 64'(frames[0] - bf), 64'(1));
      check("basic_done", 64'(dones[0] - bd), 64'(1));
      check("basic_busy0", 64'(last_busy[0]), 64'(40));
      check("basic_busy3", 64'(last_busy[1]), 64'(43));

      // Capture point with SETTLE=3: dst drops to 0 from edge N+3.
      dst = ONES; start = 1'b1;
      cyc();
      start = 1'b0;
      cyc(); cyc();
      dst = '0;
      wait_quiet(200, 1'b0);
      check("settle_early_data3", 64'(frame_data[1]), 64'(0));
      check("settle_early_par3", 64'(frame_par[1]), 64'(0));
      check("settle_early_data0", 64'(frame_data[0]), 64'(ONES));

      // Same, but dst changes after edge N+3.
      dst = ONES; start = 1'b1;
      cyc();
      start = 1'b0;
      cyc(); cyc(); cyc();
      dst = '0;
      wait_quiet(200, 1'b0);
      check("settle_late_data3", 64'(frame_data[1]), 64'(ONES));
      check("settle_late_par3", 64'(frame_par[1]), 64'(0));

      // Backpressure.
      bd = dones[0];
      dst = 38'h15_5555_5555; start = 1'b1; sout_ready = 1'($urandom_range(0, 1));
      cyc();
      start = 1'b0;
      wait_quiet(800, 1'b1);
      check("bp_data", 64'(frame_data[0]), 64'(38'h15_5555_5555));
      check("bp_parity", 64'(frame_par[0]), 64'(1));
      check("bp_data3", 64'(frame_data[1]), 64'(38'h15_5555_5555));
      check("bp_done", 64'(dones[0] - bd), 64'(1));

      // Start pulsed in SHIFT and in DONE is ignored.
      bf = frames[0]; sout_ready = 1'b1;
      dst = WIDTH'({$urandom, $urandom}); start = 1'b1;
      cyc();
      start = 1'b0;
      repeat (5) cyc();
      start = 1'b1; cyc(); start = 1'b0;
      n = 0;
      while (!done_v[0] && n < 100) begin cyc(); n++; end
      check("ign_reach_done", 64'(done_v[0]), 64'(1));
      start = 1'b1; cyc(); start = 1'b0;
      wait_quiet(100, 1'b0);
      repeat (10) cyc();
      check("ign_frames", 64'(frames[0] - bf), 64'(1));
      check("ign_idle", 64'(busy_v), 64'(0));

      // Start held through DONE into the first IDLE cycle restarts immediately.
      bf = frames[0];
      dst = WIDTH'({$urandom, $urandom}); start = 1'b1;
      cyc();
      start = 1'b0;
      n = 0;
      while (!done_v[0] && n < 100) begin cyc(); n++; end
      start = 1'b1; cyc(); cyc(); start = 1'b0;
      check("restart_busy", 64'(busy_v[0]), 64'(1));
      check("restart_valid", 64'(valid_v[0]), 64'(1));
      wait_quiet(200, 1'b0);
      check("restart_frames", 64'(frames[0] - bf), 64'(2));

      // Reset at beat 10 aborts without done; the next frame is complete.
      bf = frames[0]; bd = dones[0];
      dst = WIDTH'({$urandom, $urandom}); start = 1'b1;
      cyc();
      start = 1'b0;
      repeat (10) cyc();
      rst = 1'b1; cyc(); rst = 1'b0;
      check("mid_rst_valid", 64'(valid_v), 64'(0));
      check("mid_rst_busy", 64'(busy_v), 64'(0));
      check("mid_rst_done", 64'(done_v), 64'(0));
      val = WIDTH'({$urandom, $urandom}); dst = val; start = 1'b1;
      cyc();
      start = 1'b0;
      wait_quiet(200, 1'b0);
      check("mid_rst_nodone", 64'(dones[0] - bd), 64'(1));
      check("mid_rst_frames", 64'(frames[0] - bf), 64'(1));
      check("mid_rst_data", 64'(frame_data[0]), 64'(val));

      // Randomized frames with backpressure, stray starts, dst churn and rare resets.
      for (int f = 0; f < 40; f++) begin
         dst = WIDTH'({$urandom, $urandom}); start = 1'b1;
         sout_ready = 1'($urandom_range(0, 1));
         cyc();
         start = 1'b0;
         n = 0;
         while ((busy_v != 2'b00 || phase[0] != 0 || phase[1] != 0) && n < 600) begin
            sout_ready = ($urandom_range(0, 3) != 0);
            start = ($urandom_range(0, 9) == 0) && (busy_v == 2'b11);
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 4) == 0) dst = WIDTH'({$urandom, $urandom});
            cyc();
            n++;
         end
         rst = 1'b0; start = 1'b0;
         check("rand_budget", 64'(n < 600), 64'(1));
         repeat ($urandom_range(0, 2)) cyc();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/result_shift_out.md
# result_shift_out

Serial readout engine for the compressor-tree test harness. It is the output-side counterpart to the serial input shift register. It captures the compressor's parallel result column bits (dst0..dst{WIDTH-1}) after a programmable settle delay and shifts them out LSB-first over a one-bit valid/ready stream. Each frame ends with an even-parity bit, so a bench or an on-chip checker can collect multiplier results one pin at a time.

## Interface
- WIDTH, 38: number of result columns captured; must be ≥ 2.
- SETTLE, 0: cycles between accepting `start` and sampling `dst`, covering compressor pipeline depth; range 0..255.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  begin one readout frame; sampled only in IDLE.
- dst  input  WIDTH  compressor result bits; bit i = dstI column output.
- sout  output  1  serial data bit currently offered.
- sout_valid  output  1  `sout` holds a frame beat.
- sout_last  output  1  current beat is the parity beat, the final beat of the frame.
- sout_ready  input  1  downstream accepts the beat this cycle.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the parity beat is accepted.

## Operation
- States: IDLE, WAIT, SHIFT, DONE.
- IDLE:
  - all outputs 0.
  - `start`=1 → WAIT with settle counter loaded to SETTLE-1, or directly to SHIFT (capture) when SETTLE=0.
- WAIT:
  - counter decrements each cycle.
  - At counter==0: capture `dst` into shadow register `shreg[WIDTH-1:0]`; clear beat index; clear parity accumulator; → SHIFT.
- SHIFT, beats 0..WIDTH-1:
  - `sout`=shreg[0]; `sout_valid`=1.
  - On `sout_valid && sout_ready`: shreg shifts right by one, zero-filled; parity ^= shreg[0]; index++.
- SHIFT, beat WIDTH (parity beat):
  - `sout` = parity, the XOR of all captured bits, giving even parity over WIDTH+1 beats.
  - `sout_last`=1.
  - On accept → DONE.
- DONE: `done`=1 for exactly one cycle; `busy`=1; → IDLE unconditionally.
- Frame length is always WIDTH+1 accepted beats.
- Beat index width is clog2(WIDTH+1). Settle counter is 8 bits. No wrap-around is possible in either.
- `dst` is sampled only at the capture edge. Changes to `dst` afterwards do not affect the frame in flight.
- `start` outside IDLE is ignored; it is neither queued nor used to restart. `start` held high in DONE is also ignored. A new frame needs `start` sampled in IDLE, so the earliest restart is the cycle after DONE.
- Backpressure:
  - While `sout_valid`=1 and `sout_ready`=0, `sout`, `sout_last` and all state hold stable.
  - `sout_valid` never drops before acceptance.
  - `sout_ready` is ignored when `sout_valid`=0.

## Timing
- Reset: on any rising edge with `rst`=1, the state goes to IDLE and the following clear to 0: `sout`, `sout_valid`, `sout_last`, `busy`, `done`, the counters, shreg and the parity accumulator. Reset takes priority over every other event.
- Reset mid-frame aborts the frame without a `done` pulse. The next cycle is IDLE, and a new `start` in that cycle is honoured.
- All outputs are registered. There is no combinational path from `sout_ready` or `start` to any output.
- With `start` sampled at edge N, `dst` is captured at edge N+SETTLE. For SETTLE=0, capture happens at edge N itself.
- The first beat is valid in the cycle after the capture edge.
- With `sout_ready` tied to 1, a frame occupies exactly WIDTH+1 valid cycles plus a 1-cycle `done` pulse. `busy` is high for SETTLE+WIDTH+2 cycles in total.
- Throughput with `sout_ready`=1: one frame every SETTLE+WIDTH+3 cycles, since IDLE must be revisited for at least one cycle.

## Test plan
- Reset/idle:
  - Stimulus: assert `rst` for 2 cycles, then hold `start`=0.
  - Required: all outputs 0 throughout; `start` pulsed during `rst` is ignored.
- Basic frame, WIDTH=38, SETTLE=0, `sout_ready`=1:
  - Stimulus: `dst`=38'h20_0000_0001.
  - Required: beat 0 = 1, beats 1..36 = 0, beat 37 = 1, beat 38 = 0 with `sout_last`=1; `done` pulses the next cycle; `busy` high for 40 cycles.
- Settle and capture point, SETTLE=3:
  - Stimulus: `dst`=all-ones until edge N+2, then 0 from edge N+3.
  - Required: captured data is all zeros and parity is 0. Repeat with the change made after edge N+3: captured data is all ones and parity is 0 (38 ones).
- Backpressure:
  - Stimulus: toggle `sout_ready` pseudo-randomly on `dst`=38'h15_5555_5555.
  - Required: `sout` and `sout_last` stay stable while stalled; 39 beats reconstruct the value; parity beat = 1 (19 ones); exactly one `done` pulse.
- Ignored start:
  - Stimulus: pulse `start` in SHIFT and in DONE.
  - Required: the frame is unaffected and no second frame follows.
  - Stimulus: pulse `start` in the first IDLE cycle after DONE.
  - Required: a new frame begins immediately.
- Mid-frame reset:
  - Stimulus: assert `rst` at beat 10.
  - Required: the next cycle shows IDLE outputs with no `done`. A subsequent `start` produces a complete, correct 39-beat frame.
